booth_mult_ctrl: RTL and testbench
==================================

BOOTH_MULT_CTRL -- requirements
Module: booth_mult_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  operand-load request; accepted only when ready=1.
REQ-005 SHALL have port kill  input  1  abort of an in-flight multiply.
REQ-006 SHALL have port multiplicand  input  WIDTH  signed two's-complement operand A.
REQ-007 SHALL have port multiplier  input  WIDTH  signed two's-complement operand B.
REQ-008 SHALL have port ready  output  1  high only in IDLE.
REQ-009 SHALL have port busy  output  1  high in RUN and DONE.
REQ-010 SHALL have port result  output  WIDTH  low WIDTH bits of A*B.
REQ-011 SHALL have port result_valid  output  1  one-cycle pulse marking result and overflow valid.
REQ-012 SHALL have port overflow  output  1  signed product does not fit in WIDTH bits.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 IDLE -> RUN on start=1 and kill=0; operands captured on that edge.
REQ-015 On capture: acc = 0, Q = multiplier, M = multiplicand, q_m1 = 0, iteration counter = 0.
REQ-016 Each RUN cycle SHALL perform one radix-2 Booth step: {Q[0],q_m1}=01 -> acc+M; 10 -> acc+~M+1; 00/11 -> acc unchanged.
REQ-017 After the add, {acc,Q,q_m1} SHALL arithmetic-shift right by one, with acc sign bit replicated.
REQ-018 Add and subtract SHALL use one shared WIDTH-bit adder; subtract SHALL use inverted M with carry-in 1.
REQ-019 RUN SHALL last exactly WIDTH cycles; counter increments each RUN cycle; RUN -> DONE when counter = WIDTH-1.
REQ-020 In DONE: result = Q, overflow = NOT (acc all bits equal to Q[WIDTH-1]), result_valid = 1 for exactly one cycle; DONE -> IDLE unconditionally.
REQ-021 Latency SHALL be WIDTH+1 cycles from start-accept edge to result_valid cycle (33 for WIDTH=32).
REQ-022 result and overflow SHALL hold their last values until the next DONE.
REQ-023 start while busy=1 SHALL be ignored with no effect on operands or state.
REQ-024 kill=1 in RUN SHALL force IDLE on the next edge with no result_valid; result and overflow unchanged.
REQ-025 kill=1 in DONE SHALL be ignored; result_valid still pulses.
REQ-026 kill=1 with start=1 in IDLE: kill wins, no capture.
REQ-027 Operand changes after capture SHALL not affect the in-flight product.

Reset
REQ-028 resetn=0 SHALL immediately force state IDLE, ready=1, busy=0, result_valid=0, result=0, overflow=0, acc/Q/M/q_m1/counter=0.
REQ-029 Reset mid-RUN SHALL discard the operation with no result_valid after release.
REQ-030 First start SHALL be accepted on the first rising edge with resetn=1.

Structure
REQ-031 Shared package mult_pkg SHALL hold the state enum (IDLE, RUN, DONE), WIDTH default and iteration-count constant.
REQ-032 SHALL instantiate one sub-module, the team 32-bit carry-lookahead adder cla_32_bit, as the sole adder; its overflow/compare outputs are unused.

Verification
REQ-033 A=3, B=5, start -> result_valid exactly 33 cycles later, result=0x0000000F, overflow=0.
REQ-034 A=-7, B=6 -> result=0xFFFFFFD6, overflow=0; A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF, overflow=0.
REQ-035 A=0x00010000, B=0x00010000 -> result=0x00000000, overflow=1; A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, overflow=1.
REQ-036 Second start with new operands at cycle 10 of RUN -> ignored; first product delivered on schedule; ready=0 throughout.
REQ-037 kill at cycle 12 of RUN -> IDLE next cycle, no result_valid, previous result held; a new start then completes correctly.
REQ-038 resetn low at cycle 20 of RUN -> all outputs 0 immediately, ready=1; no result_valid after release.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the Booth multiplier
package mult_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int ITER_COUNT = WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_32_bit.sv
// rtl/cla_32_bit.sv - 32-bit two-level carry-lookahead adder
module cla_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        overflow,
  output logic        equal
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;

  // Bit generate/propagate, 4-bit group lookahead, then group carries into bit carries
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    gc[0] = cin;
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    c[32] = gc[8];
  end

  // Sum, carry-out and the signed-overflow / equality side outputs
  always_comb begin
    sum      = p ^ c[31:0];
    cout     = c[32];
    overflow = (a[31] == b[31]) && (sum[31] != a[31]);
    equal    = (a == b);
  end

endmodule

// File: rtl/booth_mult_ctrl.sv
// rtl/booth_mult_ctrl.sv - sequential radix-2 Booth signed multiplier
module booth_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             kill,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t state_q;
  state_t state_d;

  // acc carries one guard bit so that subtracting the most negative M is exact
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             q_m1;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;

  logic             do_add;
  logic             do_sub;
  logic [WIDTH-1:0] addend;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_sum;
  logic             add_cout;
  logic [32:0]      sum_ext;
  logic             unused_add_ovf;
  logic             unused_add_eq;
  logic [WIDTH:0]   acc_op;
  logic [WIDTH:0]   acc_nx;
  logic [WIDTH-1:0] q_nx;
  logic             q_m1_nx;
  logic             last_step;
  logic             capture;

  // Booth decode: subtract reuses the adder with inverted M and carry-in 1
  always_comb begin
    do_add = ({q[0], q_m1} == 2'b01);
    do_sub = ({q[0], q_m1} == 2'b10);
    addend = do_sub ? ~m : m;
    add_a  = 32'(acc[WIDTH-1:0]);
    add_b  = 32'(addend);
  end

  cla_32_bit u_adder (
    .a        (add_a),
    .b        (add_b),
    .cin      (do_sub),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow (unused_add_ovf),
    .equal    (unused_add_eq)
  );

  // Extend the adder result by the guard bit, then arithmetic-shift {acc,Q,q_m1}
  always_comb begin
    sum_ext = {add_cout, add_sum};
    acc_op  = (do_add || do_sub)
            ? {acc[WIDTH] ^ addend[WIDTH-1] ^ sum_ext[WIDTH], sum_ext[WIDTH-1:0]}
            : acc;
    {acc_nx, q_nx, q_m1_nx} = {acc_op[WIDTH], acc_op, q};
    last_step = (cnt == CNT_W'(WIDTH - 1));
    capture   = (state_q == IDLE) && start && !kill;
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: kill only matters in RUN (and blocks capture in IDLE); DONE always returns
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = RUN;
      RUN:     if (kill) state_d = IDLE;
               else if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    ready        = (state_q == IDLE);
    busy         = (state_q == RUN) || (state_q == DONE);
    result_valid = (state_q == DONE);
    result       = result_q;
    overflow     = overflow_q;
  end

  // Datapath: capture operands, one Booth step per RUN cycle, latch result on the final step
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc        <= '0;
      q          <= '0;
      m          <= '0;
      q_m1       <= 1'b0;
      cnt        <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else if (capture) begin
      acc  <= '0;
      q    <= multiplier;
      m    <= multiplicand;
      q_m1 <= 1'b0;
      cnt  <= '0;
    end else if (state_q == RUN && !kill) begin
      acc  <= acc_nx;
      q    <= q_nx;
      q_m1 <= q_m1_nx;
      cnt  <= cnt + 1'b1;
      if (last_step) begin
        result_q   <= q_nx;
        overflow_q <= (acc_nx != {(WIDTH+1){q_nx[WIDTH-1]}});
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb/tb_booth_mult_ctrl.sv - self-checking bench for booth_mult_ctrl
module tb_booth_mult_ctrl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        ready;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  booth_mult_ctrl #(.WIDTH(32)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .kill         (kill),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  // Reference: full signed product; overflow when it differs from its own low half sign-extended
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ov);
    longint p;
    p  = longint'($signed(a)) * longint'($signed(b));
    r  = p[31:0];
    ov = (p != longint'($signed(p[31:0])));
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = 32'($urandom_range(0, 40)) - 32'd20;
      1:       v = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'($urandom_range(0, 3))};
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Drive one operation; lat counts rising edges from the accept edge to the result_valid cycle
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inj_at,
                        output int lat, output logic [31:0] r, output logic ov,
                        output bit rdy_hi);
    rdy_hi = 0;
    @(negedge clock);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    while (!result_valid && lat < 40) begin
      if (ready) rdy_hi = 1;
      if (lat == inj_at) begin
        start        = 1'b1;
        multiplicand = $urandom;
        multiplier   = $urandom;
      end
      @(posedge clock);
      lat++;
      @(negedge clock);
      start = 1'b0;
    end
    r  = result;
    ov = overflow;
  endtask

  task automatic test_reset();
    logic [31:0] er;
    logic        eo;
    int          n;
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    resetn       = 1'b1;
    multiplicand = 32'd2;
    multiplier   = -32'sd3;
    start        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_start_busy got=%b exp=1", busy); end
    n = 0;
    while (!result_valid && n < 40) begin @(negedge clock); n++; end
    model(32'd2, -32'sd3, er, eo);
    checks++; if (result !== er || overflow !== eo)
      begin errors++; $display("FAIL first_start_result got=%h/%b exp=%h/%b", result, overflow, er, eo); end
  endtask

  task automatic test_directed();
    logic [31:0] ta [5] = '{32'd3, -32'sd7, 32'h7FFFFFFF, 32'h00010000, 32'h80000000};
    logic [31:0] tb [5] = '{32'd5, 32'd6, 32'd1, 32'h00010000, 32'hFFFFFFFF};
    logic [31:0] tr [5] = '{32'h0000000F, 32'hFFFFFFD6, 32'h7FFFFFFF, 32'h00000000, 32'h80000000};
    logic        to [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int          lat;
    logic [31:0] r;
    logic        ov;
    bit          rh;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], 0, lat, r, ov, rh);
      checks++; if (lat !== 33) begin errors++; $display("FAIL directed_latency[%0d] got=%0d exp=33", i, lat); end
      checks++; if (r !== tr[i]) begin errors++; $display("FAIL directed_result[%0d] got=%h exp=%h", i, r, tr[i]); end
      checks++; if (ov !== to[i]) begin errors++; $display("FAIL directed_overflow[%0d] got=%b exp=%b", i, ov, to[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, er;
    logic        ov, eo;
    int          lat;
    bit          rh;
    for (int i = 0; i < 12; i++) begin
      a = rand_operand();
      b = rand_operand();
      model(a, b, er, eo);
      run_op(a, b, 0, lat, r, ov, rh);
      checks++; if (lat !== 33 || r !== er || ov !== eo)
        begin errors++; $display("FAIL random[%0d] a=%h b=%h got=%h/%b lat=%0d exp=%h/%b lat=33", i, a, b, r, ov, lat, er, eo); end
    end
  endtask

  task automatic test_busy_start();
    logic [31:0] a, b, r, er;
    logic        ov, eo;
    int          lat;
    bit          rh;
    a = rand_operand();
    b = rand_operand();
    model(a, b, er, eo);
    run_op(a, b, 10, lat, r, ov, rh);
    checks++; if (lat !== 33) begin errors++; $display("FAIL busy_start_latency got=%0d exp=33", lat); end
    checks++; if (rh !== 1'b0) begin errors++; $display("FAIL busy_start_ready got=%b exp=0", rh); end
    checks++; if (r !== er || ov !== eo)
      begin errors++; $display("FAIL busy_start_result got=%h/%b exp=%h/%b", r, ov, er, eo); end
  endtask

  task automatic test_kill();
    logic [31:0] r, er;
    logic        ov, eo;
    int          lat, seen;
    bit          rh;
    run_op(32'd9, -32'sd9, 0, lat, r, ov, rh);
    @(negedge clock);
    multiplicand = $urandom;
    multiplier   = $urandom;
    start        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (11) @(negedge clock);
    kill = 1'b1;
    @(posedge clock);
    @(negedge clock);
    kill = 1'b0;
    checks++; if (ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL kill_idle got=ready%b/busy%b exp=ready1/busy0", ready, busy); end
    seen = 0;
    repeat (40) begin @(negedge clock); if (result_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL kill_no_valid got=%0d exp=0", seen); end
    checks++; if (result !== 32'hFFFFFFAF || overflow !== 1'b0)
      begin errors++; $display("FAIL kill_hold got=%h/%b exp=ffffffaf/0", result, overflow); end
    model(32'h12345, 32'hFFFF0003, er, eo);
    run_op(32'h12345, 32'hFFFF0003, 0, lat, r, ov, rh);
    checks++; if (lat !== 33 || r !== er || ov !== eo)
      begin errors++; $display("FAIL kill_restart got=%h/%b lat=%0d exp=%h/%b lat=33", r, ov, lat, er, eo); end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clock);
    multiplicand = 32'd1234;
    multiplier   = 32'd77;
    start        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (19) @(negedge clock);
    resetn = 1'b0;
    #1;
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0)
      begin errors++; $display("FAIL midrun_reset_status got=%b%b%b exp=100", ready, busy, result_valid); end
    checks++; if (result !== 32'h0 || overflow !== 1'b0)
      begin errors++; $display("FAIL midrun_reset_result got=%h/%b exp=0/0", result, overflow); end
    @(negedge clock);
    resetn = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clock); if (result_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrun_reset_no_valid got=%0d exp=0", seen); end
  endtask

  task automatic test_kill_edges();
    logic [31:0] er, held;
    logic        eo;
    int          n;
    model(-32'sd100, 32'd3000, er, eo);
    @(negedge clock);
    multiplicand = -32'sd100;
    multiplier   = 32'd3000;
    start        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!result_valid && n < 40) begin @(negedge clock); n++; end
    kill = 1'b1;
    checks++; if (result_valid !== 1'b1 || result !== er || overflow !== eo)
      begin errors++; $display("FAIL kill_in_done got=%b %h/%b exp=1 %h/%b", result_valid, result, overflow, er, eo); end
    @(posedge clock);
    @(negedge clock);
    kill = 1'b0;
    checks++; if (result_valid !== 1'b0 || ready !== 1'b1)
      begin errors++; $display("FAIL done_one_pulse got=valid%b/ready%b exp=valid0/ready1", result_valid, ready); end
    held = result;
    multiplicand = 32'd5;
    multiplier   = 32'd5;
    start        = 1'b1;
    kill         = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    kill  = 1'b0;
    checks++; if (ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL kill_beats_start got=ready%b/busy%b exp=ready1/busy0", ready, busy); end
    checks++; if (result !== er) begin errors++; $display("FAIL kill_beats_start_hold got=%h exp=%h", result, held); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, r, er;
    logic        ov, eo;
    int          lat;
    bit          rh;
    for (int i = 0; i < 3; i++) begin
      a = rand_operand();
      b = rand_operand();
      model(a, b, er, eo);
      run_op(a, b, 0, lat, r, ov, rh);
      checks++; if (lat !== 33 || r !== er || ov !== eo)
        begin errors++; $display("FAIL back_to_back[%0d] got=%h/%b lat=%0d exp=%h/%b lat=33", i, r, ov, lat, er, eo); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_start();
    test_kill();
    test_reset_mid_run();
    test_kill_edges();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
